pivot_rom_cache: RTL and testbench

// - Responder for the toggle-style rom_req/rom_ack ROM fetch port of the pivot (roz) layer chip.
// - Serves 16-bit words from a direct-mapped cache of 64-bit lines.
// - On a miss, fetches one 64-bit line from the SDRAM controller over a second toggle handshake.
// - Sits between the roz tile fetcher and an SDRAM channel; cuts SDRAM traffic for repeated tile rows.

---
 rtl/pivot_rom_cache_if.sv | 24 ++
 rtl/pivot_rom_cache.sv | 121 ++++++++++++
 tb/tb_pivot_rom_cache.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pivot_rom_cache_if.sv
// ROM fetch (client) and SDRAM line-fetch toggle handshakes of the roz pivot-layer cache.
// Both sides use req/ack toggles. slave = cache side, master = client + SDRAM side.
interface pivot_rom_cache_if #(
   parameter int ADDR_W = 27
);
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_req;
   logic              rom_ack;
   logic [15:0]       rom_data;
   logic [ADDR_W-1:0] sdr_addr;
   logic              sdr_req;
   logic              sdr_ack;
   logic [63:0]       sdr_data;

   modport slave (
      input  rom_addr, rom_req, sdr_ack, sdr_data,
      output rom_ack, rom_data, sdr_addr, sdr_req
   );

   modport master (
      output rom_addr, rom_req, sdr_ack, sdr_data,
      input  rom_ack, rom_data, sdr_addr, sdr_req
   );
endinterface

// File: rtl/pivot_rom_cache.sv
// Direct-mapped 64-bit-line cache answering 16-bit ROM reads. Hit: 3 cycles req->ack; miss adds SDRAM time.
// One request outstanding; the client waits on the rom_ack toggle, the cache waits on the sdr_ack toggle.
module pivot_rom_cache #(
   parameter int LINES  = 16,
   parameter int ADDR_W = 27
) (
   input  logic              clk,
   input  logic              reset_n,
   pivot_rom_cache_if.slave  bus,
   input  logic              flush,
   output logic [15:0]       hits,
   output logic [15:0]       misses
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 3;

   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       line_dat [LINES];
   logic [TAG_W-1:0]  line_tag [LINES];
   logic [LINES-1:0]  line_vld;

   logic              ack_q;
   logic              req_q;
   logic [15:0]       data_q;
   logic [ADDR_W-1:0] sdr_addr_q;
   logic              miss_q;
   logic              fill_flushed;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [1:0]        word;
   logic              hit;
   logic              fill_done;

   assign idx       = addr_q[IDX_W+2:3];
   assign tag       = addr_q[ADDR_W-1:IDX_W+3];
   assign word      = addr_q[2:1];
   assign hit       = line_vld[idx] && (line_tag[idx] == tag);
   assign fill_done = (state == FILL) && (bus.sdr_ack == req_q);

   assign bus.rom_ack  = ack_q;
   assign bus.rom_data = data_q;
   assign bus.sdr_req  = req_q;
   assign bus.sdr_addr = sdr_addr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.rom_req != ack_q) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = hit ? RESPOND : FILL;
         FILL:    if (fill_done) state_nxt = RESPOND;
         RESPOND: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q       <= '0;
         line_vld     <= '0;
         ack_q        <= 1'b0;
         req_q        <= 1'b0;
         data_q       <= '0;
         sdr_addr_q   <= '0;
         miss_q       <= 1'b0;
         fill_flushed <= 1'b0;
         hits         <= '0;
         misses       <= '0;
      end else begin
         case (state)
            IDLE: if (bus.rom_req != ack_q) addr_q <= bus.rom_addr;
            LOOKUP: begin
               if (hit) begin
                  data_q <= line_dat[idx][{word, 4'b0000} +: 16];
                  miss_q <= 1'b0;
               end else begin
                  sdr_addr_q   <= {addr_q[ADDR_W-1:3], 3'b000};
                  req_q        <= ~req_q;
                  miss_q       <= 1'b1;
                  fill_flushed <= 1'b0;
               end
            end
            FILL: begin
               // A flush seen at any point of the fill keeps the arriving line invalid.
               if (flush)     fill_flushed <= 1'b1;
               if (fill_done) data_q <= bus.sdr_data[{word, 4'b0000} +: 16];
            end
            RESPOND: begin
               ack_q <= bus.rom_req;
               if (miss_q) begin
                  if (misses != 16'hFFFF) misses <= misses + 16'd1;
               end else begin
                  if (hits != 16'hFFFF) hits <= hits + 16'd1;
               end
            end
            default: ;
         endcase

         if (flush)
            line_vld <= '0;
         else if (fill_done && !fill_flushed)
            line_vld[idx] <= 1'b1;
      end
   end

   // Line payload needs no reset: it is only read when the valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_dat[idx] <= bus.sdr_data;
         line_tag[idx] <= tag;
      end
   end
endmodule

// File: tb/tb_pivot_rom_cache.sv
// Bench for pivot_rom_cache: residency-map model of the cache, ROM contents from a fixed function,
// a per-cycle compare process, an SDRAM responder with programmable latency, directed and random requests.
module tb_pivot_rom_cache;
   localparam int LINES  = 16;
   localparam int ADDR_W = 27;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] hits, misses;

   pivot_rom_cache_if #(.ADDR_W(ADDR_W)) bus ();

   pivot_rom_cache #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .flush   (flush),
      .hits    (hits),
      .misses  (misses)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: which line address each slot holds, plus expected counters and held data.
   bit          m_valid [LINES];
   int unsigned m_line  [LINES];
   int          m_hits, m_misses;
   logic [15:0] held;
   bit          pend, pend_hit, pend_flushed;
   logic [26:0] pend_addr;
   int          cyc = 0, req_cyc, last_lat, req_toggles, sdr_toggles = 0;
   int          sdr_lat = 2;
   bit          resp_en = 1'b1;
   logic        prev_ack, prev_sreq;

   localparam logic [26:0] A = 27'h0123456;
   localparam logic [26:0] B = 27'h0123456 + 27'd128;
   localparam logic [26:0] C = 27'h0123456 + 27'd256;

   function automatic logic [63:0] line_val(input logic [23:0] la);
      if (la == 24'h02468A) return 64'h4444_3333_2222_1111;
      return {la[7:0] ^ 8'hA5, la, 8'h3C, la ^ 24'h5A5A5A};
   endfunction

   function automatic logic [15:0] exp_word(input logic [26:0] a);
      logic [63:0] l;
      l = line_val(a[26:3]);
      return l[a[2:1]*16 +: 16];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic summary_and_finish();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_hits = 0; m_misses = 0; held = '0; pend = 1'b0;
   endtask

   task automatic req_start(input logic [26:0] a);
      pend_addr    = a;
      pend_hit     = m_valid[a[6:3]] && (m_line[a[6:3]] == a[26:3]);
      pend_flushed = 1'b0;
      req_toggles  = 0;
      req_cyc      = cyc;
      bus.rom_addr = a;
      pend         = 1'b1;
      bus.rom_req  = ~bus.rom_req;
   endtask

   task automatic req(input logic [26:0] a);
      req_start(a);
      for (int i = 0; i < 300 && pend; i++) @(negedge clk);
      if (pend) begin
         chk("req_timeout", pend, 1'b0);
         summary_and_finish();
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      if (pend && !pend_hit) pend_flushed = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      bus.rom_req  = 1'b0;
      bus.rom_addr = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // SDRAM responder: completes a line fetch sdr_lat negedges after first seeing the request.
   initial begin
      int cnt;
      cnt = 0;
      bus.sdr_ack  = 1'b0;
      bus.sdr_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            bus.sdr_ack = 1'b0;
            cnt = 0;
         end else if (resp_en && (bus.sdr_req != bus.sdr_ack)) begin
            if (cnt >= sdr_lat) begin
               bus.sdr_data = line_val(bus.sdr_addr[26:3]);
               bus.sdr_ack  = bus.sdr_req;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Compare process, one sample per cycle just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset_n) begin
            if (bus.sdr_req != prev_sreq) begin
               req_toggles++;
               sdr_toggles++;
               chk("sdr_req_on_miss_only", pend && !pend_hit, 1'b1);
               chk("sdr_addr", bus.sdr_addr, {pend_addr[26:3], 3'b000});
            end
            if (bus.rom_ack != prev_ack) begin
               chk("ack_while_pending", pend, 1'b1);
               chk("ack_equals_req", bus.rom_ack, bus.rom_req);
               chk("rom_data", bus.rom_data, exp_word(pend_addr));
               if (pend_hit) m_hits++;
               else begin
                  m_misses++;
                  if (!pend_flushed) begin
                     m_valid[pend_addr[6:3]] = 1'b1;
                     m_line[pend_addr[6:3]]  = pend_addr[26:3];
                  end
               end
               chk("hits", hits, m_hits);
               chk("misses", misses, m_misses);
               last_lat = cyc - req_cyc;
               chk("latency", last_lat, pend_hit ? 3 : 4 + sdr_lat);
               chk("sdr_toggles_per_req", req_toggles, pend_hit ? 0 : 1);
               held = exp_word(pend_addr);
               pend = 1'b0;
            end else if (!pend) begin
               chk("rom_data_held", bus.rom_data, held);
               chk("hits_stable", hits, m_hits);
               chk("misses_stable", misses, m_misses);
               chk("idle_ack", bus.rom_ack, bus.rom_req);
            end else begin
               chk("hits_pending", hits, m_hits);
               chk("misses_pending", misses, m_misses);
            end
         end
         prev_ack  = bus.rom_ack;
         prev_sreq = bus.sdr_req;
      end
   end

   initial begin
      #2_000_000;
      chk("global_timeout", 1'b1, reset_n ^ reset_n);
      summary_and_finish();
   end

   initial begin
      int s0;
      logic [19:0] tags [3];
      logic [26:0] a;
      tags[0] = 20'h00246; tags[1] = 20'h00247; tags[2] = 20'h12345;

      bus.rom_addr = '0;
      bus.rom_req  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rom_ack", bus.rom_ack, 1'b0);
      chk("rst_rom_data", bus.rom_data, 16'h0);
      chk("rst_sdr_req", bus.sdr_req, 1'b0);
      chk("rst_sdr_addr", bus.sdr_addr, 27'h0);
      chk("rst_hits", hits, 16'h0);
      chk("rst_misses", misses, 16'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Cold miss, then hit on another word of the same line.
      sdr_lat = 10;
      s0 = sdr_toggles;
      req(A);
      chk("cold_data", bus.rom_data, 16'h4444);
      chk("cold_misses", misses, 16'd1);
      chk("cold_sdr_toggles", sdr_toggles - s0, 1);
      chk("cold_sdr_addr", bus.sdr_addr, 27'h0123450);
      chk("cold_latency", last_lat, 14);
      s0 = sdr_toggles;
      req(27'h0123450);
      chk("hit_data", bus.rom_data, 16'h1111);
      chk("hit_hits", hits, 16'd1);
      chk("hit_sdr_toggles", sdr_toggles - s0, 0);
      chk("hit_latency", last_lat, 3);

      // Conflict on the same index evicts the first line.
      s0 = sdr_toggles;
      req(B);
      req(A);
      chk("conflict_sdr_toggles", sdr_toggles - s0, 2);
      chk("conflict_data", bus.rom_data, 16'h4444);
      chk("conflict_misses", misses, 16'd3);

      // Flush while idle.
      pulse_flush();
      s0 = sdr_toggles;
      req(A);
      chk("flush_idle_refetch", sdr_toggles - s0, 1);

      // Flush in the middle of a fill, then in the very cycle the fill lands.
      fork
         req(B);
         begin repeat (4) @(negedge clk); pulse_flush(); end
      join
      s0 = sdr_toggles;
      req(B);
      chk("flush_midfill_refetch", sdr_toggles - s0, 1);
      fork
         req(A);
         begin repeat (2 + sdr_lat) @(negedge clk); pulse_flush(); end
      join
      s0 = sdr_toggles;
      req(A);
      chk("flush_samecycle_refetch", sdr_toggles - s0, 1);

      // Back-to-back hits, toggled the cycle after the ack.
      s0 = hits;
      req(A);
      req(A ^ 27'h2);
      chk("b2b_hits", hits - s0, 16'd2);
      chk("b2b_latency", last_lat, 3);

      // Reset while waiting on SDRAM, then a stale sdr_ack toggle.
      resp_en = 1'b0;
      req_start(C);
      repeat (5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_rom_ack", bus.rom_ack, 1'b0);
      chk("arst_sdr_req", bus.sdr_req, 1'b0);
      chk("arst_sdr_addr", bus.sdr_addr, 27'h0);
      chk("arst_rom_data", bus.rom_data, 16'h0);
      chk("arst_hits", hits, 16'h0);
      chk("arst_misses", misses, 16'h0);
      model_reset();
      bus.rom_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      s0 = sdr_toggles;
      @(negedge clk);
      bus.sdr_ack = 1'b1;
      repeat (5) @(negedge clk);
      bus.sdr_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("stale_ack_no_req", sdr_toggles - s0, 0);
      chk("stale_ack_no_resp", bus.rom_ack, 1'b0);
      resp_en = 1'b1;
      req(C);
      chk("post_reset_misses", misses, 16'd1);

      // Random mix of hits, misses and occasional flushes.
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1))};
         sdr_lat = $urandom_range(1, 6);
         if ($urandom_range(0, 49) == 0) pulse_flush();
         req(a);
      end
      chk("random_total", 32'(hits) + 32'(misses), 1000);

      repeat (3) @(negedge clk);
      summary_and_finish();
   end
endmodule
